bpu_gshare: RTL and testbench

BPU_GSHARE -- requirements
Module: bpu_gshare

---
 rtl/bpu_gshare_pkg.sv | 27 ++
 rtl/config_pkg.sv | 23 ++
 rtl/bpu_sat_counter.sv | 29 ++
 rtl/bpu_gshare.sv | 182 ++++++++++++++++++
 tb/tb_bpu_gshare.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bpu_gshare_pkg.sv
// -----------------------------------------------------------------------------
// bpu_gshare_pkg
// Shared frontend definitions for the branch predictor:
//   bpu_ctr_t   : 2-bit saturating counter (MSB = predicted taken)
//   CTR_RESET   : value every entry is swept to after reset (weakly not-taken)
//   CTR_MIN/MAX : saturation bounds
//   bpu_state_e : predictor FSM states (table init sweep, normal operation)
// -----------------------------------------------------------------------------
package bpu_gshare_pkg;

    typedef logic [1:0] bpu_ctr_t;

    localparam bpu_ctr_t CTR_RESET = 2'b01;
    localparam bpu_ctr_t CTR_MIN   = 2'b00;
    localparam bpu_ctr_t CTR_MAX   = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bpu_state_e;

    // Direction predicted by a counter value.
    function automatic logic ctr_taken(input bpu_ctr_t ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/config_pkg.sv
// -----------------------------------------------------------------------------
// config_pkg
// Build-time configuration shared by the frontend blocks.
//   cfg_t    : XLEN (fetch address width), frontend_predict_LEN (P, pattern
//              table index width), frontedn_hash_LEN (H, global history width).
//   TestCfg  : the team test configuration (XLEN=32, P=10, H=5).
// P must be a multiple of H so the history can be tiled across the index.
// -----------------------------------------------------------------------------
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned frontend_predict_LEN;
        int unsigned frontedn_hash_LEN;
    } cfg_t;

    localparam cfg_t TestCfg = '{
        XLEN:                 32,
        frontend_predict_LEN: 10,
        frontedn_hash_LEN:    5
    };

endpackage

// File: rtl/bpu_sat_counter.sv
// -----------------------------------------------------------------------------
// bpu_sat_counter
// Combinational next-value of a 2-bit saturating counter.
//   cur   : current counter value
//   taken : resolved branch outcome (1 = increment, 0 = decrement)
//   nxt   : next counter value, clamped to [0,3]
// -----------------------------------------------------------------------------
module bpu_sat_counter
    import bpu_gshare_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != CTR_MAX) begin
                nxt = cur + 2'd1;
            end
        end else begin
            if (cur != CTR_MIN) begin
                nxt = cur - 2'd1;
            end
        end
    end

endmodule

// File: rtl/bpu_gshare.sv
// -----------------------------------------------------------------------------
// bpu_gshare
// Gshare direction predictor: a table of 2^P 2-bit saturating counters indexed
// by PC[P+1:2] XOR the global history (tiled P/H times).
//
// Ports
//   clk_i         : clock, rising edge
//   rst_ni        : asynchronous active-low reset
//   pred_valid_i  : fetch requests a prediction
//   pred_pc_i     : fetch PC (XLEN bits)
//   pred_ready_o  : predictor accepts requests (low during the init sweep)
//   resp_valid_o  : one-cycle pulse, one cycle after an accepted request
//   resp_taken_o  : predicted direction (counter MSB)
//   resp_idx_o    : table index used; returned later on upd_idx_i
//   upd_valid_i   : resolved branch update
//   upd_idx_i     : index previously reported on resp_idx_o
//   upd_taken_i   : actual outcome
//
// Configuration macro
//   GSHARE_HISTORY_EN : defined   -> gshare (PC XOR global history)
//                       undefined -> bimodal (PC bits only, no history state)
//
// After reset the table is swept one entry per cycle to weakly not-taken;
// requests and updates are ignored until the sweep finishes. A prediction and
// an update to the same entry in the same cycle return the old counter value.
// -----------------------------------------------------------------------------
module bpu_gshare
    import bpu_gshare_pkg::*;
#(
    parameter config_pkg::cfg_t Cfg = config_pkg::TestCfg
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 pred_valid_i,
    input  logic [Cfg.XLEN-1:0]                  pred_pc_i,
    output logic                                 pred_ready_o,
    output logic                                 resp_valid_o,
    output logic                                 resp_taken_o,
    output logic [Cfg.frontend_predict_LEN-1:0]  resp_idx_o,
    input  logic                                 upd_valid_i,
    input  logic [Cfg.frontend_predict_LEN-1:0]  upd_idx_i,
    input  logic                                 upd_taken_i
);

    localparam int P     = int'(Cfg.frontend_predict_LEN);
    localparam int XLEN  = int'(Cfg.XLEN);
    localparam int DEPTH = 1 << P;

    // ---------------------------------------------------------------- state
    bpu_state_e   state_reg;
    logic [P-1:0] sweep_reg;
    logic         ready_reg;
    logic         resp_valid_reg;
    logic [P-1:0] resp_idx_reg;

    logic         run;
    logic         accept;
    logic         upd_apply;

    assign run       = (state_reg == ST_RUN);
    assign accept    = run && pred_valid_i;
    assign upd_apply = run && upd_valid_i;

    // --------------------------------------------------------- index hashing
    logic [P-1:0] pc_bits;
    logic [P-1:0] pred_idx;

    assign pc_bits = pred_pc_i[P+1:2];

    // Address bits outside the index field do not affect the prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc_i[XLEN-1:P+2], pred_pc_i[1:0]};

`ifdef GSHARE_HISTORY_EN
    localparam int H = int'(Cfg.frontedn_hash_LEN);

    logic [H-1:0] ghr_reg;
    logic [P-1:0] hist_tiled;

    // History tiled across the whole index so every index bit is hashed.
    for (genvar gi = 0; gi < P / H; gi++) begin : g_hist_tile
        assign hist_tiled[gi*H +: H] = ghr_reg;
    end

    // ghr_reg is the pre-update value, so a same-cycle update does not
    // influence the index of the request in that cycle.
    assign pred_idx = pc_bits ^ hist_tiled;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ghr_reg <= '0;
        end else if (upd_apply) begin
            ghr_reg <= {ghr_reg[H-2:0], upd_taken_i};
        end
    end
`else
    assign pred_idx = pc_bits;
`endif

    // ------------------------------------------------------- pattern table
    bpu_ctr_t     ctr_table [DEPTH];
    bpu_ctr_t     rd_ctr_reg;
    logic [1:0]   upd_ctr_cur;
    logic [1:0]   upd_ctr_next;

    logic         tbl_we;
    logic [P-1:0] tbl_waddr;
    bpu_ctr_t     tbl_wdata;

    assign upd_ctr_cur = ctr_table[upd_idx_i];

    bpu_sat_counter u_sat_counter (
        .cur   (upd_ctr_cur),
        .taken (upd_taken_i),
        .nxt   (upd_ctr_next)
    );

    // One write port shared between the init sweep and branch updates; the
    // two never overlap because updates are only honoured in RUN.
    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = sweep_reg;
        tbl_wdata = CTR_RESET;
        if (!run) begin
            tbl_we = 1'b1;
        end else if (upd_valid_i) begin
            tbl_we    = 1'b1;
            tbl_waddr = upd_idx_i;
            tbl_wdata = upd_ctr_next;
        end
    end

    // Read-first: the registered read sees the value before a same-cycle
    // write, which gives the required "old value wins" collision behaviour.
    always_ff @(posedge clk_i) begin
        if (tbl_we) begin
            ctr_table[tbl_waddr] <= tbl_wdata;
        end
        rd_ctr_reg <= ctr_table[pred_idx];
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= ST_INIT;
            sweep_reg      <= '0;
            ready_reg      <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_idx_reg   <= '0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    resp_valid_reg <= 1'b0;
                    sweep_reg      <= sweep_reg + P'(1);
                    // The last entry is written in the same cycle the FSM
                    // moves to RUN; the counter wraps back to zero.
                    if (sweep_reg == '1) begin
                        state_reg <= ST_RUN;
                        ready_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    resp_valid_reg <= accept;
                    if (accept) begin
                        resp_idx_reg <= pred_idx;
                    end
                end
                default: begin
                    state_reg <= ST_INIT;
                end
            endcase
        end
    end

    assign pred_ready_o = ready_reg;
    assign resp_valid_o = resp_valid_reg;
    assign resp_idx_o   = resp_idx_reg;
    // Qualified by valid so the direction output reads 0 whenever no
    // response is being presented, including straight after reset.
    assign resp_taken_o = resp_valid_reg & ctr_taken(rd_ctr_reg);

endmodule

// File: tb/tb_bpu_gshare.sv
// -----------------------------------------------------------------------------
// tb_bpu_gshare
// Self-checking bench for bpu_gshare (default configuration P=10, H=5).
// A behavioural model (integer counters clamped to 0..3, integer history)
// predicts every response; directed steps pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_bpu_gshare;

    localparam int P = 10;
    localparam int H = 5;
    localparam int DEPTH = 1 << P;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          pred_valid_i = 1'b0;
    logic [31:0]   pred_pc_i = '0;
    logic          pred_ready_o;
    logic          resp_valid_o;
    logic          resp_taken_o;
    logic [P-1:0]  resp_idx_o;
    logic          upd_valid_i = 1'b0;
    logic [P-1:0]  upd_idx_i = '0;
    logic          upd_taken_i = 1'b0;

    bpu_gshare dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .pred_valid_i (pred_valid_i),
        .pred_pc_i    (pred_pc_i),
        .pred_ready_o (pred_ready_o),
        .resp_valid_o (resp_valid_o),
        .resp_taken_o (resp_taken_o),
        .resp_idx_o   (resp_idx_o),
        .upd_valid_i  (upd_valid_i),
        .upd_idx_i    (upd_idx_i),
        .upd_taken_i  (upd_taken_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------- model
    int m_tbl [DEPTH];
    int m_ghr;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = 1;
        m_ghr = 0;
    endtask

    function automatic int model_idx(input logic [31:0] pc);
        int r;
        r = int'((pc >> 2) & 32'h3FF);
`ifdef GSHARE_HISTORY_EN
        for (int k = 0; k < P / H; k++) r = r ^ (m_ghr << (k * H));
`endif
        return r;
    endfunction

    // PC whose hashed index (under the current model history) equals idx.
    function automatic logic [31:0] pc_for(input int idx);
        int pc_field;
        pc_field = idx ^ model_idx(32'h8000_0000);
        return 32'h8000_0000 | (32'(pc_field) << 2);
    endfunction

    task automatic model_update(input logic [P-1:0] ui, input logic ut);
        int i;
        i = int'(ui);
        if (ut) m_tbl[i] = (m_tbl[i] >= 3) ? 3 : m_tbl[i] + 1;
        else    m_tbl[i] = (m_tbl[i] <= 0) ? 0 : m_tbl[i] - 1;
        m_ghr = ((m_ghr << 1) | int'(ut)) & ((1 << H) - 1);
    endtask

    // ------------------------------------------------------------ checks
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One RUN cycle: drive, predict from the model, compare one cycle later.
    task automatic step(input logic pv, input logic [31:0] pc, input logic uv,
                        input logic [P-1:0] ui, input logic ut, input string tag);
        int  exp_idx;
        logic exp_taken;
        @(negedge clk_i);
        pred_valid_i = pv;
        pred_pc_i    = pc;
        upd_valid_i  = uv;
        upd_idx_i    = ui;
        upd_taken_i  = ut;
        exp_idx   = model_idx(pc);
        exp_taken = (m_tbl[exp_idx] >= 2);
        if (uv) model_update(ui, ut);
        @(posedge clk_i);
        #1;
        chk({tag, "_ready"}, 32'(pred_ready_o), 32'd1);
        chk({tag, "_valid"}, 32'(resp_valid_o), 32'(pv));
        if (pv) begin
            chk({tag, "_idx"},   32'(resp_idx_o),   32'(exp_idx));
            chk({tag, "_taken"}, 32'(resp_taken_o), 32'(exp_taken));
        end
        $display("txn %-10s pv=%0b pc=%08h uv=%0b ui=%03h ut=%0b -> v=%0b idx=%03h t=%0b",
                 tag, pv, pc, uv, ui, ut, resp_valid_o, resp_idx_o, resp_taken_o);
    endtask

    task automatic idle();
        pred_valid_i = 1'b0;
        upd_valid_i  = 1'b0;
        upd_taken_i  = 1'b0;
    endtask

    // Count cycles from reset release until ready rises; requests and
    // updates are held active throughout and must all be ignored.
    task automatic wait_init(input string tag);
        int cyc = 0;
        int spurious = 0;
        pred_valid_i = 1'b1;
        pred_pc_i    = 32'h8000_0100;   // index 0x040 (history is zero)
        upd_valid_i  = 1'b1;
        upd_idx_i    = 10'h040;
        upd_taken_i  = 1'b1;
        rst_ni       = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (resp_valid_o) spurious++;
            if (pred_ready_o) break;
        end
        idle();
        chk({tag, "_init_len"}, 32'(cyc), 32'd1024);
        chk({tag, "_init_noresp"}, 32'(spurious), 32'd0);
        $display("txn %-10s init sweep took %0d cycles", tag, cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        logic [P-1:0] ui;
        logic pv, uv, ut;

        // Reset state with a request held active.
        pred_valid_i = 1'b1;
        pred_pc_i    = 32'h8000_0ABC;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready", 32'(pred_ready_o), 32'd0);
        chk("rst_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_taken", 32'(resp_taken_o), 32'd0);
        chk("rst_idx",   32'(resp_idx_o),   32'd0);

        model_reset();
        @(negedge clk_i);
        wait_init("boot");

        // Fresh table: weakly not-taken at index 0.
        step(1, 32'h8000_0000, 0, '0, 0, "pc0");
        chk("pc0_idx_lit",   32'(resp_idx_o),   32'h000);
        chk("pc0_taken_lit", 32'(resp_taken_o), 32'd0);

        // Two taken updates make 0x010 predict taken.
        step(0, '0, 1, 10'h010, 1, "up010t");
        step(0, '0, 1, 10'h010, 1, "up010t");
        step(1, pc_for(32'h010), 0, '0, 0, "pr010");
        chk("pr010_idx_lit",   32'(resp_idx_o),   32'h010);
        chk("pr010_taken_lit", 32'(resp_taken_o), 32'd1);

        // Four not-taken updates saturate at 0.
        for (int i = 0; i < 4; i++) step(0, '0, 1, 10'h010, 0, "up010n");
        chk("sat0_model", 32'(m_tbl[16]), 32'd0);
        step(1, pc_for(32'h010), 0, '0, 0, "pr010b");
        chk("pr010b_taken_lit", 32'(resp_taken_o), 32'd0);

        // Same-cycle predict + taken update on 0x020: old value returned.
        pc = pc_for(32'h020);
        step(1, pc, 1, 10'h020, 1, "coll020");
        chk("coll020_idx_lit",   32'(resp_idx_o),   32'h020);
        chk("coll020_taken_lit", 32'(resp_taken_o), 32'd0);
        step(1, pc_for(32'h020), 0, '0, 0, "rep020");
        chk("rep020_taken_lit", 32'(resp_taken_o), 32'd1);

`ifdef GSHARE_HISTORY_EN
        // Five taken outcomes fill the history with ones.
        for (int i = 0; i < 5; i++) step(0, '0, 1, 10'h100, 1, "ghr_fill");
        step(1, 32'h8000_0000, 0, '0, 0, "ghr_all1");
        chk("ghr_all1_idx_lit", 32'(resp_idx_o), 32'h3FF);
`endif

        // Randomized traffic with frequent index collisions.
        for (int n = 0; n < 400; n++) begin
            pv = 1'($urandom_range(0, 1));
            uv = 1'($urandom_range(0, 1));
            ut = 1'($urandom_range(0, 1));
            pc = $urandom();
            if ($urandom_range(0, 1) == 1) pc = {pc[31:6], 6'b0} | 32'($urandom_range(0, 7) << 2);
            case ($urandom_range(0, 2))
                0:       ui = P'($urandom_range(0, 7));
                1:       ui = P'(model_idx(pc));
                default: ui = P'($urandom());
            endcase
            step(pv, pc, uv, ui, ut, "rand");
        end

        // Reset while a response is being presented.
        step(1, 32'h8000_0ABC, 0, '0, 0, "pending");
        #1;
        rst_ni = 1'b0;
        #1;
        chk("midrst_valid", 32'(resp_valid_o), 32'd0);
        chk("midrst_ready", 32'(pred_ready_o), 32'd0);
        chk("midrst_idx",   32'(resp_idx_o),   32'd0);
        chk("midrst_taken", 32'(resp_taken_o), 32'd0);
        idle();
        repeat (2) @(posedge clk_i);
        model_reset();
        @(negedge clk_i);
        wait_init("resweep");

        // Updates held during the sweep must have been ignored.
        step(1, 32'h8000_0100, 0, '0, 0, "post040");
        chk("post040_idx_lit",   32'(resp_idx_o),   32'h040);
        chk("post040_taken_lit", 32'(resp_taken_o), 32'd0);

        for (int n = 0; n < 100; n++) begin
            pc = $urandom();
            ui = P'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)), ui,
                 1'($urandom_range(0, 1)), "rand2");
        end

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
